// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
//   Parametrised UART receive framer with its own bit-period timer.
//   Supports 5..9 data bits (LSB first), none/even/odd parity and 1 or 2
//   stop bits. Each received word is delivered through a valid/ready output
//   register together with its parity and framing status; a word that
//   completes while the register is still full is dropped and flagged with
//   an overrun pulse.
//
//   Optional build macro: UART_RX_MAJORITY_EN
//     defined   : each bit is the 2-of-3 majority of three consecutive
//                 synchronised samples around the sample point
//     undefined : a single synchronised sample at the sample point
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   rx             in   async serial line, idle high
//   en             in   receiver enable; low forces the FSM to IDLE
//   data           out  received word, stable while data_valid
//   data_valid     out  word available; held until data_ready
//   data_ready     in   consumer accepts on data_valid && data_ready
//   parity_error   out  parity status of the held word
//   framing_error  out  framing status of the held word (a stop bit was 0)
//   overrun        out  1-cycle pulse: a word was lost because the register was full
//   glitch         out  1-cycle pulse: start bit found high at its centre
//   busy           out  high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int CLK_FREQ_HZ = 1_600_000,
  parameter int BAUD_RATE   = 100_000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 en,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 glitch,
  output logic                 busy
);

  localparam int BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
  localparam int TW         = $clog2(BIT_CYCLES + 1);
  // The detection cycle in IDLE already counts as the first cycle of the
  // half bit, so the countdown starts one lower than BIT_CYCLES/2.
  localparam logic [TW-1:0] HALF_LOAD = TW'(BIT_CYCLES / 2 - 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(BIT_CYCLES - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam bit            HAS_PARITY = (PARITY_MODE != 0);
  localparam bit            ODD_PARITY = (PARITY_MODE == 2);

  if (BIT_CYCLES < 8) begin : g_bit_cycles_check
    $error("uart_rx_frame: CLK_FREQ_HZ/BAUD_RATE must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_bits_check
    $error("uart_rx_frame: DATA_BITS must be 5..9");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
  } state_t;

  state_t                 state, state_n;
  logic [TW-1:0]          timer;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err;
  logic                   ferr;
  logic                   rx_meta, rx_s, rx_q;
  logic                   bit_val;
  logic                   in_frame, tick, start_det;
  logic                   last_data, last_stop, complete, frame_ferr;

  // Synchroniser; rx_q is one more delay used for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Window is rx_qq/rx_q/rx_s at the decision cycle, i.e. -1/0/+1 around a
  // nominal centre one cycle earlier, so the decision edge does not move.
  logic rx_qq;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_qq <= 1'b1;
    else        rx_qq <= rx_q;
  end
  assign bit_val = (rx_s & rx_q) | (rx_s & rx_qq) | (rx_q & rx_qq);
`else
  assign bit_val = rx_s;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    if (!en) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (start_det) state_n = S_START;
        S_START:  if (tick) state_n = bit_val ? S_IDLE : S_DATA;
        S_DATA:   if (tick && last_data) state_n = HAS_PARITY ? S_PARITY : S_STOP;
        S_PARITY: if (tick) state_n = S_STOP;
        S_STOP:   if (complete) state_n = (frame_ferr && !rx_s) ? S_BRK : S_IDLE;
        S_BRK:    if (rx_s) state_n = S_IDLE;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  // FSM outputs and control strobes
  always_comb begin
    busy       = (state != S_IDLE);
    in_frame   = (state == S_START) || (state == S_DATA) ||
                 (state == S_PARITY) || (state == S_STOP);
    start_det  = en && (state == S_IDLE) && !rx_s && rx_q;
    tick       = en && in_frame && (timer == '0);
    last_data  = (bit_cnt == LAST_DATA);
    last_stop  = (bit_cnt == LAST_STOP);
    complete   = tick && (state == S_STOP) && last_stop;
    frame_ferr = ferr | ~bit_val;
  end

  // Timer, shift register and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer         <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_err       <= 1'b0;
      ferr          <= 1'b0;
      data          <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      glitch        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      glitch  <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;

      if (!en || !in_frame) begin
        timer   <= start_det ? HALF_LOAD : '0;
        bit_cnt <= '0;
      end else if (tick) begin
        timer <= BIT_LOAD;
        unique case (state)
          S_START: begin
            glitch  <= bit_val;
            par_err <= 1'b0;
            ferr    <= 1'b0;
          end
          S_DATA: begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
          end
          S_PARITY: par_err <= (((^shreg) ^ bit_val) != ODD_PARITY);
          S_STOP: begin
            ferr    <= frame_ferr;
            bit_cnt <= bit_cnt + 4'd1;
            if (last_stop) begin
              // A consumer accepting this very cycle frees the register.
              if (!data_valid || data_ready) begin
                data          <= shreg;
                parity_error  <= par_err;
                framing_error <= frame_ferr;
                data_valid    <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end else begin
        timer <= timer - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [2:0] en_v;
  logic [2:0] rdy_v;

  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2;
  logic ov0, ov1, ov2, gl0, gl1, gl2, bz0, bz1, bz2;

  always #5 clk = ~clk;

  // u0: 8N1, u1: 7 data bits even parity, u2: 8 data bits 2 stop bits
  uart_rx_frame u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .en(en_v[0]), .data(d0), .data_valid(dv0),
    .data_ready(rdy_v[0]), .parity_error(pe0), .framing_error(fe0), .overrun(ov0),
    .glitch(gl0), .busy(bz0));

  uart_rx_frame #(.DATA_BITS(7), .PARITY_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .en(en_v[1]), .data(d1), .data_valid(dv1),
    .data_ready(rdy_v[1]), .parity_error(pe1), .framing_error(fe1), .overrun(ov1),
    .glitch(gl1), .busy(bz1));

  uart_rx_frame #(.STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .en(en_v[2]), .data(d2), .data_valid(dv2),
    .data_ready(rdy_v[2]), .parity_error(pe2), .framing_error(fe2), .overrun(ov2),
    .glitch(gl2), .busy(bz2));

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    int         dut;
    logic [8:0] word;
    logic       pflip;
    logic [1:0] stops;   // bit 0 is the first stop bit on the line
    logic [8:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  exp_t q0[$], q1[$], q2[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int rise0 = 0;
  int gl_cnt0 = 0, ov_cnt0 = 0, ov_cnt1 = 0, ov_cnt2 = 0, dvr0 = 0;
  logic dv0_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int id, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    int   sz;
    case (id)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_word dut%0d: got %0h, expected none", id, d);
    end else begin
      case (id)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("data dut%0d", id), 32'(d), 32'(e.d));
      chk($sformatf("parity_error dut%0d", id), 32'(pe), 32'(e.pe));
      chk($sformatf("framing_error dut%0d", id), 32'(fe), 32'(e.fe));
    end
  endtask

  // Output monitor: words are consumed on data_valid && data_ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dv0 && rdy_v[0]) pop_chk(0, {1'b0, d0}, pe0, fe0);
      if (dv1 && rdy_v[1]) pop_chk(1, {2'b00, d1}, pe1, fe1);
      if (dv2 && rdy_v[2]) pop_chk(2, {1'b0, d2}, pe2, fe2);
      if (gl0) gl_cnt0++;
      if (ov0) ov_cnt0++;
      if (ov1) ov_cnt1++;
      if (ov2) ov_cnt2++;
      if (dv0 && !dv0_q) begin
        rise0 = cyc;
        dvr0++;
      end
      dv0_q = dv0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame at 16 cycles per bit. abort_at: bit index at which all
  // enables drop; spike_at: bit index that gets a 1-cycle inversion at cycle 7.
  task automatic send_frame(input int nb, input logic [8:0] w, input bit has_par,
                            input logic pbit, input int nstop, input logic [1:0] stops,
                            input int abort_at, input int spike_at);
    logic bits [16];
    int   n;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nb; i++) begin bits[n] = w[i]; n++; end
    if (has_par) begin bits[n] = pbit; n++; end
    for (int i = 0; i < nstop; i++) begin bits[n] = stops[i]; n++; end
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) en_v = '0;
      for (int c = 0; c < 16; c++) begin
        rx = (i == spike_at && c == 7) ? ~bits[i] : bits[i];
        if (i == 0 && c == 0) fall_cyc = cyc;
        step(1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [11];
    int   gl_b, ov_b, dvr_b;

    vt[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    vt[1]  = '{0, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
    vt[2]  = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
    vt[3]  = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
    vt[4]  = '{0, 9'h081, 1'b0, 2'b00, 9'h081, 1'b0, 1'b1};
    vt[5]  = '{1, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
    vt[6]  = '{1, 9'h055, 1'b1, 2'b11, 9'h055, 1'b1, 1'b0};
    vt[7]  = '{1, 9'h001, 1'b0, 2'b11, 9'h001, 1'b0, 1'b0};
    vt[8]  = '{2, 9'h03C, 1'b0, 2'b01, 9'h03C, 1'b0, 1'b1};
    vt[9]  = '{2, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
    vt[10] = '{2, 9'h0A5, 1'b0, 2'b10, 9'h0A5, 1'b0, 1'b1};

    rst_n = 1'b0;
    rx    = 1'b1;
    en_v  = '0;
    rdy_v = 3'b111;
    step(3);
    chk("reset outputs dut0", {dv0, pe0, fe0, ov0, gl0, bz0, d0}, '0);
    chk("reset outputs dut1", {dv1, pe1, fe1, ov1, gl1, bz1, d1}, '0);
    chk("reset outputs dut2", {dv2, pe2, fe2, ov2, gl2, bz2, d2}, '0);
    rst_n = 1'b1;
    step(3);
    chk("post-reset idle dut0", {dv0, ov0, gl0, bz0, d0}, '0);

    // Latency and back-to-back frames on 8N1, ready held high.
    en_v = 3'b001;
    push(0, 9'h0A5, 1'b0, 1'b0);
    push(0, 9'h03C, 1'b0, 1'b0);
    send_frame(8, 9'h0A5, 1'b0, 1'b0, 1, 2'b11, -1, -1);
    chk("data_valid latency", 32'(rise0 - fall_cyc), 32'(2 + 8 + 9 * 16 + 1));
    send_frame(8, 9'h03C, 1'b0, 1'b0, 1, 2'b11, -1, -1);
    rx = 1'b1;
    step(24);

    // Table-driven frames across the three formats.
    for (int v = 0; v < 11; v++) begin
      int   nb;
      int   ns;
      logic pbit;
      nb   = (vt[v].dut == 1) ? 7 : 8;
      ns   = (vt[v].dut == 2) ? 2 : 1;
      pbit = (^vt[v].word[6:0]) ^ vt[v].pflip;
      push(vt[v].dut, vt[v].exp_d, vt[v].exp_pe, vt[v].exp_fe);
      en_v = '0;
      en_v[vt[v].dut] = 1'b1;
      send_frame(nb, vt[v].word, vt[v].dut == 1, pbit, ns, vt[v].stops, -1, -1);
      rx = 1'b1;
      step(24);
    end

    // Overrun: two frames with ready low; the second is lost.
    en_v = 3'b001;
    rdy_v[0] = 1'b0;
    ov_b = ov_cnt0;
    push(0, 9'h011, 1'b0, 1'b0);
    send_frame(8, 9'h011, 1'b0, 1'b0, 1, 2'b11, -1, -1);
    send_frame(8, 9'h022, 1'b0, 1'b0, 1, 2'b11, -1, -1);
    rx = 1'b1;
    step(8);
    chk("overrun held data", 32'(d0), 32'h11);
    chk("overrun held valid", 32'(dv0), 32'd1);
    chk("overrun pulse count", 32'(ov_cnt0 - ov_b), 32'd1);
    rdy_v[0] = 1'b1;
    step(4);
    chk("valid cleared after accept", 32'(dv0), 32'd0);
    push(0, 9'h033, 1'b0, 1'b0);
    send_frame(8, 9'h033, 1'b0, 1'b0, 1, 2'b11, -1, -1);
    rx = 1'b1;
    step(24);

    // Short low pulse on idle line: one glitch, no word.
    gl_b  = gl_cnt0;
    dvr_b = dvr0;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(12);
    chk("busy low after glitch", 32'(bz0), 32'd0);
    step(16);
    chk("glitch pulse count", 32'(gl_cnt0 - gl_b), 32'd1);
    chk("no word from glitch", 32'(dvr0 - dvr_b), 32'd0);

    // Enable dropped at data bit 3, then a clean frame.
    dvr_b = dvr0;
    ov_b  = ov_cnt0;
    gl_b  = gl_cnt0;
    send_frame(8, 9'h05A, 1'b0, 1'b0, 1, 2'b11, 4, -1);
    chk("busy low after abort", 32'(bz0), 32'd0);
    rx = 1'b1;
    step(24);
    chk("no word from abort", 32'(dvr0 - dvr_b), 32'd0);
    chk("no pulses from abort", 32'((ov_cnt0 - ov_b) + (gl_cnt0 - gl_b)), 32'd0);
    en_v = 3'b001;
    push(0, 9'h07E, 1'b0, 1'b0);
    send_frame(8, 9'h07E, 1'b0, 1'b0, 1, 2'b11, -1, -1);
    rx = 1'b1;
    step(24);

    // Second stop bit low and line held low: break until rx returns high.
    en_v = 3'b100;
    push(2, 9'h03C, 1'b0, 1'b1);
    send_frame(8, 9'h03C, 1'b0, 1'b0, 2, 2'b01, -1, -1);
    step(48);
    chk("break holds busy", 32'(bz2), 32'd1);
    rx = 1'b1;
    step(4);
    chk("break released", 32'(bz2), 32'd0);
    push(2, 9'h0C3, 1'b0, 1'b0);
    send_frame(8, 9'h0C3, 1'b0, 1'b0, 2, 2'b11, -1, -1);
    rx = 1'b1;
    step(24);

`ifdef UART_RX_MAJORITY_EN
    // A single-cycle inversion inside data bit 2 must be voted out.
    en_v = 3'b001;
    push(0, 9'h096, 1'b0, 1'b0);
    send_frame(8, 9'h096, 1'b0, 1'b0, 1, 2'b11, -1, 3);
    rx = 1'b1;
    step(24);
`endif

    step(10);
    chk("dut0 words outstanding", 32'(q0.size()), 32'd0);
    chk("dut1 words outstanding", 32'(q1.size()), 32'd0);
    chk("dut2 words outstanding", 32'(q2.size()), 32'd0);
    chk("dut0 total glitches", 32'(gl_cnt0), 32'd1);
    chk("dut0 total overruns", 32'(ov_cnt0), 32'd1);
    chk("dut1/dut2 overruns", 32'(ov_cnt1 + ov_cnt2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
